// File: rtl/key_pulse_gen_pkg.sv
// Shared definitions for the key pulse generator: debounce state encoding
// and a helper that sizes counters for a given terminal count.
package key_pulse_gen_pkg;

    // Debounce FSM states; the encoding is fixed so state dumps read the same
    // across both key instances and any downstream debug tooling.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        PRESSED    = 2'd2,
        REL_WAIT   = 2'd3
    } db_state_t;

    // Width of a counter that must hold values 0 .. n-1. A terminal count of
    // one still needs a one-bit register so the vector is never zero-width.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_pulse_gen_debounce.sv
// One push-button conditioner: two-flop synchroniser, four-state debounce FSM
// and its stability counter. Emits a single-cycle PRESS_EVT per accepted
// press and reports ACTIVE whenever the FSM is away from IDLE.
module key_debounce
    import key_pulse_gen_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic KEY,
    output logic PRESS_EVT,
    output logic ACTIVE
);

    localparam int unsigned CW = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          s;
    db_state_t     state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;

    // Bring the raw asynchronous key into the clock domain; only s is used
    // after this point.
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the
    // two synchroniser stages into one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], KEY};
        end
    end

    assign s = sync_q[1];

    // State and stability counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state, counter update and press event. The counter stops at
    // CNT_MAX because that is exactly where the FSM leaves the wait state,
    // so it can never wrap.
    always_comb begin
        // NOTE: every output of this block is given a default before the case
        // so that no path leaves a signal unassigned, which would infer a latch.
        state_nx  = state;
        cnt_nx    = cnt;
        PRESS_EVT = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    state_nx = PRESS_WAIT;
                    cnt_nx   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_nx = IDLE;
                end else if (cnt == CNT_MAX) begin
                    state_nx  = PRESSED;
                    PRESS_EVT = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_nx = REL_WAIT;
                    cnt_nx   = '0;
                end
            end
            REL_WAIT: begin
                // A bounce back to 1 during release returns to PRESSED without
                // a new event; only a full stable-low run gets back to IDLE.
                if (s) begin
                    state_nx = PRESSED;
                end else if (cnt == CNT_MAX) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign ACTIVE = (state != IDLE);

endmodule

// File: rtl/key_pulse_gen.sv
// Control-strobe generator for the 4-bit counter. Debounces the count and
// load buttons, runs a free-running auto-mode divider, resolves load-over-
// count priority and registers EN (active-high) and LOAD (active-low) so the
// counter's asynchronous load input never sees a combinational glitch.
module key_pulse_gen
    import key_pulse_gen_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned DIV       = 5000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic KEY_CNT,
    input  logic KEY_LD,
    input  logic AUTO,
    output logic EN,
    output logic LOAD,
    output logic BUSY
);

    localparam int unsigned DW = cnt_width(DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

    logic          cnt_event;
    logic          ld_event;
    logic          cnt_active;
    logic          ld_active;
    logic [DW-1:0] div_q;
    logic          tick;
    logic          en_nx;
    logic          load_nx;

    key_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_cnt (
        .CLK       (CLK),
        .RST       (RST),
        .KEY       (KEY_CNT),
        .PRESS_EVT (cnt_event),
        .ACTIVE    (cnt_active)
    );

    key_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_ld (
        .CLK       (CLK),
        .RST       (RST),
        .KEY       (KEY_LD),
        .PRESS_EVT (ld_event),
        .ACTIVE    (ld_active)
    );

    // Free-running divider, counting in both modes so switching AUTO on
    // picks up an already-running phase rather than restarting it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_q <= '0;
        end else if (div_q == DIV_MAX) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign tick = (div_q == DIV_MAX);

    // Strobe selection: AUTO picks the count source, a load event suppresses
    // any count strobe in the same cycle, and the lost count is not queued.
    always_comb begin
        en_nx   = (AUTO ? tick : cnt_event) & ~ld_event;
        load_nx = ~ld_event;
    end

    // Output flops; LOAD idles high because the counter loads on low.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            EN   <= 1'b0;
            LOAD <= 1'b1;
        end else begin
            EN   <= en_nx;
            LOAD <= load_nx;
        end
    end

    assign BUSY = cnt_active | ld_active;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Self-checking bench for key_pulse_gen with DB_CYCLES=4, DIV=5. A run-length
// model of the debounce rule and a modulo model of the divider predict EN,
// LOAD and BUSY every cycle; directed phases add literal timing expectations.
module tb_key_pulse_gen;

    localparam int unsigned DB  = 4;
    localparam int unsigned DV  = 5;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic KEY_CNT = 1'b0;
    logic KEY_LD = 1'b0;
    logic AUTO = 1'b0;
    logic EN;
    logic LOAD;
    logic BUSY;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    key_pulse_gen #(
        .DB_CYCLES (DB),
        .DIV       (DV)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .KEY_CNT (KEY_CNT),
        .KEY_LD  (KEY_LD),
        .AUTO    (AUTO),
        .EN      (EN),
        .LOAD    (LOAD),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each key is described by its accepted level and the length of the
    // current run of synchronised samples that disagree with it. A run of
    // DB+1 disagreeing samples flips the level (the sample that starts the
    // run plus DB qualifying samples); a rising flip is a press event.
    // The synchronised sample seen in a cycle is the raw key two edges back.
    logic [1:0] m_lvl = 2'b00;
    int         m_run [2] = '{0, 0};
    logic [1:0] m_d1 = 2'b00;
    logic [1:0] m_d2 = 2'b00;
    int         mdiv = 0;
    logic       exp_en = 1'b0;
    logic       exp_ld = 1'b1;
    logic       exp_busy = 1'b0;

    always @(posedge CLK) begin
        logic [1:0] s;
        logic [1:0] evt;
        logic       tk;
        cyc++;
        if (RST) begin
            m_lvl    = 2'b00;
            m_run    = '{0, 0};
            m_d1     = 2'b00;
            m_d2     = 2'b00;
            mdiv     = 0;
            exp_en   = 1'b0;
            exp_ld   = 1'b1;
            exp_busy = 1'b0;
        end else begin
            s   = m_d2;
            evt = 2'b00;
            for (int k = 0; k < 2; k++) begin
                if (s[k] != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DB + 1) begin
                        m_lvl[k] = s[k];
                        m_run[k] = 0;
                        evt[k]   = s[k];
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            tk       = (mdiv == DV - 1);
            mdiv     = (mdiv + 1) % DV;
            exp_en   = (AUTO ? tk : evt[0]) & ~evt[1];
            exp_ld   = ~evt[1];
            exp_busy = (m_lvl != 2'b00) || (m_run[0] != 0) || (m_run[1] != 0);
            m_d2     = m_d1;
            m_d1     = {KEY_LD, KEY_CNT};
        end
    end

    // ---------------- per-cycle compare and pulse monitor ----------------
    int en_cnt = 0;
    int en_first = -1;
    int en_prev = -1;
    int en_gap = 0;
    int ld_low_cnt = 0;
    int busy_cnt = 0;

    always @(negedge CLK) begin
        if (RST) begin
            check("rst_en", int'(EN), 0);
            check("rst_load", int'(LOAD), 1);
            check("rst_busy", int'(BUSY), 0);
        end else begin
            check("en", int'(EN), int'(exp_en));
            check("load", int'(LOAD), int'(exp_ld));
            check("busy", int'(BUSY), int'(exp_busy));
            if (EN === 1'b1) begin
                if (en_cnt == 0) en_first = cyc;
                if (en_prev >= 0) en_gap = cyc - en_prev;
                en_prev = cyc;
                en_cnt++;
            end
            if (LOAD === 1'b0) ld_low_cnt++;
            if (BUSY === 1'b1) busy_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic clr_mon();
        en_cnt = 0;
        en_first = -1;
        en_prev = -1;
        en_gap = 0;
        ld_low_cnt = 0;
        busy_cnt = 0;
    endtask

    initial begin
        int mark;
        int waited;
        int hold_c;
        int hold_l;

        // 1. reset held then released, keys idle
        step(3);
        RST = 1'b0;
        clr_mon();
        step(20);
        check("idle_en_pulses", en_cnt, 0);
        check("idle_load_lows", ld_low_cnt, 0);
        check("idle_busy", busy_cnt, 0);

        // 2. clean press held 10 cycles: one EN, 7 cycles after the rise
        clr_mon();
        KEY_CNT = 1'b1;
        mark = cyc;
        step(10);
        KEY_CNT = 1'b0;
        step(12);
        check("press_en_pulses", en_cnt, 1);
        check("press_latency", en_first - mark, 7);

        // 3. bouncing press and bouncing release
        clr_mon();
        KEY_CNT = 1'b1; step(1);
        KEY_CNT = 1'b0; step(1);
        KEY_CNT = 1'b1; step(1);
        KEY_CNT = 1'b0; step(1);
        KEY_CNT = 1'b1;
        mark = cyc;
        step(10);
        KEY_CNT = 1'b0; step(1);
        KEY_CNT = 1'b1; step(1);
        KEY_CNT = 1'b0;
        step(12);
        check("bounce_en_pulses", en_cnt, 1);
        check("bounce_latency", en_first - mark, 7);

        // 4. auto mode: one strobe every 5 cycles; key presses add nothing
        clr_mon();
        AUTO = 1'b1;
        step(20);
        check("auto_en_pulses", en_cnt, 4);
        check("auto_period", en_gap, 5);
        clr_mon();
        KEY_CNT = 1'b1;
        step(10);
        KEY_CNT = 1'b0;
        step(15);
        check("auto_key_ignored", en_cnt, 5);

        // 5. load event coinciding with a divider tick: load wins
        waited = 0;
        while (mdiv != 3 && waited < 10) begin
            step(1);
            waited++;
        end
        check("align_found", int'(mdiv == 3), 1);
        KEY_LD = 1'b1;
        mark = cyc;
        for (int i = 0; i < 22; i++) begin
            if (i == 10) KEY_LD = 1'b0;
            step(1);
            if (cyc == mark + 7) begin
                check("collide_load", int'(LOAD), 0);
                check("collide_en", int'(EN), 0);
            end
            if (cyc == mark + 12) begin
                check("next_tick_en", int'(EN), 1);
                check("next_tick_load", int'(LOAD), 1);
            end
        end

        // 6. reset mid-qualification with the key still held
        AUTO = 1'b0;
        clr_mon();
        KEY_CNT = 1'b1;
        step(5);
        RST = 1'b1;
        step(2);
        RST = 1'b0;
        mark = cyc;
        step(15);
        KEY_CNT = 1'b0;
        check("rst_requal_pulses", en_cnt, 1);
        check("rst_requal_latency", en_first - mark, 7);
        step(10);

        // 7. randomized keys, mode changes and occasional resets
        hold_c = 0;
        hold_l = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold_c == 0) begin
                KEY_CNT = 1'($urandom_range(0, 1));
                hold_c = $urandom_range(1, 9);
            end
            if (hold_l == 0) begin
                KEY_LD = 1'($urandom_range(0, 1));
                hold_l = $urandom_range(1, 9);
            end
            hold_c--;
            hold_l--;
            if ($urandom_range(0, 99) == 0) AUTO = ~AUTO;
            RST = ($urandom_range(0, 299) == 0);
            step(1);
        end
        RST = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
